// File: rtl/e203_exu_lpipe_wbck_rob.sv
// Long-pipe writeback collector: captures out-of-order LSU/divider results by ITAG
// and retires them in order against the OITF retire pointer.
module e203_exu_lpipe_wbck_rob #(
    parameter int OITF_DEPTH  = 2,
    parameter int ITAG_WIDTH  = 1,
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int PC_SIZE     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic [ITAG_WIDTH-1:0]  lsu_itag,
    input  logic [XLEN-1:0]        lsu_wdat,
    input  logic                   lsu_err,

    input  logic                   div_valid,
    output logic                   div_ready,
    input  logic [ITAG_WIDTH-1:0]  div_itag,
    input  logic [XLEN-1:0]        div_wdat,

    input  logic                   oitf_empty,
    input  logic [ITAG_WIDTH-1:0]  oitf_ret_ptr,
    input  logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx,
    input  logic                   oitf_ret_rdwen,
    input  logic                   oitf_ret_rdfpu,
    input  logic [PC_SIZE-1:0]     oitf_ret_pc,
    output logic                   oitf_ret_ena,

    output logic                   wbck_valid,
    input  logic                   wbck_ready,
    output logic [XLEN-1:0]        wbck_wdat,
    output logic [RFIDX_WIDTH-1:0] wbck_rdidx,
    output logic                   wbck_rdfpu,

    output logic                   excp_valid,
    input  logic                   excp_ready,
    output logic [PC_SIZE-1:0]     excp_pc,

    output logic [15:0]            retire_cnt
);

    logic [OITF_DEPTH-1:0] buf_vld;
    logic [OITF_DEPTH-1:0] buf_vld_nxt;
    logic [XLEN-1:0]       buf_dat [OITF_DEPTH];
    logic                  buf_err [OITF_DEPTH];

    logic lsu_fire;
    logic div_fire;
    logic head_vld;
    logic head_err;
    logic nowrite_fire;
    logic fire;

    always_comb begin
        // LSU takes priority when both pipes present the same ITAG
        lsu_ready = rst_n & ~buf_vld[lsu_itag];
        div_ready = rst_n & ~buf_vld[div_itag] & ~(lsu_valid & (lsu_itag == div_itag));
        lsu_fire  = lsu_valid & lsu_ready;
        div_fire  = div_valid & div_ready;
    end

    always_comb begin
        head_vld     = ~oitf_empty & buf_vld[oitf_ret_ptr];
        head_err     = buf_err[oitf_ret_ptr];
        excp_valid   = rst_n & head_vld & head_err;
        wbck_valid   = rst_n & head_vld & ~head_err & oitf_ret_rdwen;
        nowrite_fire = rst_n & head_vld & ~head_err & ~oitf_ret_rdwen;
        fire         = (excp_valid & excp_ready) | (wbck_valid & wbck_ready) | nowrite_fire;
        oitf_ret_ena = fire;
        wbck_wdat    = buf_dat[oitf_ret_ptr];
        wbck_rdidx   = oitf_ret_rdidx;
        wbck_rdfpu   = oitf_ret_rdfpu;
        excp_pc      = oitf_ret_pc;
    end

    always_comb begin
        buf_vld_nxt = buf_vld;
        if (fire)
            buf_vld_nxt[oitf_ret_ptr] = 1'b0;
        if (lsu_fire)
            buf_vld_nxt[lsu_itag] = 1'b1;
        if (div_fire)
            buf_vld_nxt[div_itag] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_vld    <= '0;
            retire_cnt <= '0;
        end else begin
            buf_vld <= buf_vld_nxt;
            if (fire)
                retire_cnt <= retire_cnt + 16'd1;
        end
    end

    // Payload storage is deliberately left unreset; only the valid bits matter
    always_ff @(posedge clk) begin
        if (lsu_fire) begin
            buf_dat[lsu_itag] <= lsu_wdat;
            buf_err[lsu_itag] <= lsu_err;
        end
        if (div_fire) begin
            buf_dat[div_itag] <= div_wdat;
            buf_err[div_itag] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_e203_exu_lpipe_wbck_rob.sv
// Directed table-driven bench for the long-pipe writeback collector.
module tb_e203_exu_lpipe_wbck_rob;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_valid, lsu_ready, lsu_err;
    logic [0:0]  lsu_itag;
    logic [31:0] lsu_wdat;
    logic        div_valid, div_ready;
    logic [0:0]  div_itag;
    logic [31:0] div_wdat;
    logic        oitf_empty;
    logic [0:0]  oitf_ret_ptr;
    logic [4:0]  oitf_ret_rdidx;
    logic        oitf_ret_rdwen, oitf_ret_rdfpu;
    logic [31:0] oitf_ret_pc;
    logic        oitf_ret_ena;
    logic        wbck_valid, wbck_ready, wbck_rdfpu;
    logic [31:0] wbck_wdat;
    logic [4:0]  wbck_rdidx;
    logic        excp_valid, excp_ready;
    logic [31:0] excp_pc;
    logic [15:0] retire_cnt;

    int checks = 0;
    int failures = 0;

    e203_exu_lpipe_wbck_rob #(
        .OITF_DEPTH(2), .ITAG_WIDTH(1), .XLEN(32), .RFIDX_WIDTH(5), .PC_SIZE(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_itag(lsu_itag),
        .lsu_wdat(lsu_wdat), .lsu_err(lsu_err),
        .div_valid(div_valid), .div_ready(div_ready), .div_itag(div_itag), .div_wdat(div_wdat),
        .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr), .oitf_ret_rdidx(oitf_ret_rdidx),
        .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_rdfpu(oitf_ret_rdfpu), .oitf_ret_pc(oitf_ret_pc),
        .oitf_ret_ena(oitf_ret_ena),
        .wbck_valid(wbck_valid), .wbck_ready(wbck_ready), .wbck_wdat(wbck_wdat),
        .wbck_rdidx(wbck_rdidx), .wbck_rdfpu(wbck_rdfpu),
        .excp_valid(excp_valid), .excp_ready(excp_ready), .excp_pc(excp_pc),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, lv, li, le, dv, di, ptr, wen, fpu, wr, er;
        logic [31:0] ld, dd, pc;
        logic [4:0]  idx;
        logic        lr, dr, ena, wv, ev;
        logic [31:0] wd;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(int rst, int lv, int li, int ld, int le, int dv, int di, int dd,
                               int ptr, int idx, int wen, int fpu, int pc, int wr, int er,
                               int lr, int dr, int ena, int wv, int ev, int wd, int cnt);
        vec_t r;
        r.rst = 1'(rst); r.lv = 1'(lv); r.li = 1'(li); r.ld = 32'(ld); r.le = 1'(le);
        r.dv = 1'(dv); r.di = 1'(di); r.dd = 32'(dd); r.ptr = 1'(ptr); r.idx = 5'(idx);
        r.wen = 1'(wen); r.fpu = 1'(fpu); r.pc = 32'(pc); r.wr = 1'(wr); r.er = 1'(er);
        r.lr = 1'(lr); r.dr = 1'(dr); r.ena = 1'(ena); r.wv = 1'(wv); r.ev = 1'(ev);
        r.wd = 32'(wd); r.cnt = 16'(cnt);
        return r;
    endfunction

    task automatic chk(input int row, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL row%0d %s actual=%h required=%h", row, nm, act, exp);
        end
    endtask

    initial begin
        // rst lv li ld le dv di dd ptr idx wen fpu pc wr er | lr dr ena wv ev wd cnt
        tbl.push_back(v(0,1,0,0,0,1,1,0,0,5,1,0,0,1,1, 0,0,0,0,0,0,0));                 // in reset
        tbl.push_back(v(1,1,0,'h1234,0,0,1,0,0,5,1,0,0,1,0, 1,1,0,0,0,0,0));            // capture itag0
        tbl.push_back(v(1,0,0,0,0,0,1,0,0,5,1,0,0,1,0, 0,1,1,1,0,'h1234,0));            // retire next cycle
        tbl.push_back(v(1,0,0,0,0,0,1,0,0,5,1,0,0,1,0, 1,1,0,0,0,0,1));
        tbl.push_back(v(1,0,0,0,0,1,1,'hBEEF,0,5,1,0,0,1,0, 1,1,0,0,0,0,1));            // div itag1 first
        tbl.push_back(v(1,0,0,0,0,0,1,0,0,5,1,0,0,1,0, 1,0,0,0,0,0,1));
        tbl.push_back(v(1,1,0,'hAAAA,0,0,1,0,0,5,1,0,0,1,0, 1,0,0,0,0,0,1));            // lsu itag0 later
        tbl.push_back(v(1,0,0,0,0,0,1,0,0,6,1,0,0,1,0, 0,0,1,1,0,'hAAAA,1));
        tbl.push_back(v(1,0,0,0,0,0,1,0,1,7,1,1,0,1,0, 1,0,1,1,0,'hBEEF,2));
        tbl.push_back(v(1,1,0,'h5555,0,0,1,0,0,8,1,0,0,0,0, 1,1,0,0,0,0,3));            // backpressure
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(1,0,0,0,0,0,1,0,0,8,1,0,0,0,0, 0,1,0,1,0,'h5555,3));
        tbl.push_back(v(1,0,0,0,0,0,1,0,0,8,1,0,0,1,0, 0,1,1,1,0,'h5555,3));
        tbl.push_back(v(1,1,0,'hDEAD,1,0,1,0,0,9,1,0,'h80000010,1,0, 1,1,0,0,0,0,4));   // exception
        tbl.push_back(v(1,0,0,0,0,0,1,0,0,9,1,0,'h80000010,1,0, 0,1,0,0,1,0,4));
        tbl.push_back(v(1,0,0,0,0,0,1,0,0,9,1,0,'h80000010,1,1, 0,1,1,0,1,0,4));
        tbl.push_back(v(1,1,1,'h1111,0,1,1,'h2222,0,5,1,0,0,1,0, 1,0,0,0,0,0,5));       // collision
        tbl.push_back(v(1,0,0,0,0,0,1,0,1,5,0,0,0,0,0, 1,0,1,0,0,0,5));                 // rdwen=0 head
        tbl.push_back(v(1,0,0,0,0,0,1,0,1,5,1,0,0,1,0, 1,1,0,0,0,0,6));
        tbl.push_back(v(1,1,0,'h3333,0,1,1,'h4444,0,5,1,0,0,0,0, 1,1,0,0,0,0,6));       // fill both
        tbl.push_back(v(1,0,0,0,0,0,1,0,0,5,1,0,0,0,0, 0,0,0,1,0,'h3333,6));
        tbl.push_back(v(0,1,0,0,0,1,1,0,0,5,1,0,0,1,1, 0,0,0,0,0,0,6));                 // reset mid-op
        tbl.push_back(v(1,0,0,0,0,0,1,0,0,5,1,0,0,1,0, 1,1,0,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,1,0,1,5,1,0,0,1,0, 1,1,0,0,0,0,0));

        rst_n = 1'b0; lsu_valid = 1'b0; lsu_itag = '0; lsu_wdat = '0; lsu_err = 1'b0;
        div_valid = 1'b0; div_itag = '0; div_wdat = '0; oitf_empty = 1'b0; oitf_ret_ptr = '0;
        oitf_ret_rdidx = '0; oitf_ret_rdwen = 1'b0; oitf_ret_rdfpu = 1'b0; oitf_ret_pc = '0;
        wbck_ready = 1'b0; excp_ready = 1'b0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            #1;
            rst_n = tbl[i].rst; lsu_valid = tbl[i].lv; lsu_itag = tbl[i].li; lsu_wdat = tbl[i].ld;
            lsu_err = tbl[i].le; div_valid = tbl[i].dv; div_itag = tbl[i].di; div_wdat = tbl[i].dd;
            oitf_empty = 1'b0; oitf_ret_ptr = tbl[i].ptr; oitf_ret_rdidx = tbl[i].idx;
            oitf_ret_rdwen = tbl[i].wen; oitf_ret_rdfpu = tbl[i].fpu; oitf_ret_pc = tbl[i].pc;
            wbck_ready = tbl[i].wr; excp_ready = tbl[i].er;
            @(negedge clk);
            chk(i, "lsu_ready",    32'(lsu_ready),    32'(tbl[i].lr));
            chk(i, "div_ready",    32'(div_ready),    32'(tbl[i].dr));
            chk(i, "oitf_ret_ena", 32'(oitf_ret_ena), 32'(tbl[i].ena));
            chk(i, "wbck_valid",   32'(wbck_valid),   32'(tbl[i].wv));
            chk(i, "excp_valid",   32'(excp_valid),   32'(tbl[i].ev));
            chk(i, "retire_cnt",   32'(retire_cnt),   32'(tbl[i].cnt));
            if (tbl[i].wv) begin
                chk(i, "wbck_wdat",  wbck_wdat,         tbl[i].wd);
                chk(i, "wbck_rdidx", 32'(wbck_rdidx),   32'(tbl[i].idx));
                chk(i, "wbck_rdfpu", 32'(wbck_rdfpu),   32'(tbl[i].fpu));
            end
            if (tbl[i].ev)
                chk(i, "excp_pc", excp_pc, 32'h8000_0010);
            @(posedge clk);
        end

        // Entry captured while the FIFO reports empty must wait for it to fill
        begin
            int lat;
            bit found;
            #1;
            rst_n = 1'b1; lsu_valid = 1'b1; lsu_itag = 1'b0; lsu_wdat = 32'h7777; lsu_err = 1'b0;
            div_valid = 1'b0; oitf_empty = 1'b1; oitf_ret_ptr = 1'b0; oitf_ret_rdidx = 5'd3;
            oitf_ret_rdwen = 1'b1; oitf_ret_rdfpu = 1'b0; wbck_ready = 1'b1; excp_ready = 1'b0;
            @(negedge clk);
            chk(100, "empty_capture_ready", 32'(lsu_ready), 32'd1);
            @(posedge clk);
            #1 lsu_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk(101 + k, "empty_hold_ena",   32'(oitf_ret_ena), 32'd0);
                chk(101 + k, "empty_hold_valid", 32'(wbck_valid),   32'd0);
                @(posedge clk);
            end
            #1 oitf_empty = 1'b0;
            found = 1'b0;
            lat = 99;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (oitf_ret_ena === 1'b1) begin
                    found = 1'b1;
                    lat = k;
                    chk(110, "held_wdat", wbck_wdat, 32'h7777);
                    break;
                end
                @(posedge clk);
            end
            chk(111, "held_retire_latency", 32'(lat), 32'd0);
            if (found) @(posedge clk);
            #1;
            chk(112, "held_retire_cnt", 32'(retire_cnt), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
